bram_vector_fetch: RTL
======================

Name: bram_vector_fetch

Overview:
- Sequencer for the 32-bit dual-port vector BRAM (2^13 words). Fetches 128-bit test vectors stored as four adjacent words, using both read ports in two read cycles per vector.
- Presents each assembled vector to the downstream pin driver through a valid/ready handshake.
- Started by the host-side command logic with a base address and a vector count.

Parameters:
- RAM_WIDTH, 32, BRAM word width; vector width is 4*RAM_WIDTH.
- RAM_ADDR_BITS, 13, BRAM address width.
- CNT_BITS, 12, width of the vector count and index (max 4095 vectors).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle start pulse; sampled only in IDLE.
- BASE_ADDR  in  RAM_ADDR_BITS  word address of vector 0; low 2 bits ignored (forced 0).
- NUM_VEC  in  CNT_BITS  number of vectors to fetch.
- BUSY  out  1  high from the accepted START until DONE.
- DONE  out  1  one-cycle pulse when the run completes.
- EN_A, EN_B  out  1  BRAM port enables.
- WE_A, WE_B  out  1  BRAM write enables; constant 0.
- ADDR_A, ADDR_B  out  RAM_ADDR_BITS  BRAM addresses.
- DIN_A, DIN_B  out  RAM_WIDTH  constant 0.
- DOUT_A, DOUT_B  in  RAM_WIDTH  BRAM read data (registered, 1-cycle latency).
- VEC_OUT  out  4*RAM_WIDTH  assembled vector.
- VEC_VALID  out  1  VEC_OUT holds a valid vector.
- VEC_READY  in  1  consumer accepts when VEC_VALID && VEC_READY.
- VEC_INDEX  out  CNT_BITS  index of the vector on VEC_OUT (0-based).

Behaviour:
- Reset: the asynchronous RST forces state=IDLE and drives all outputs to 0, including VEC_OUT, VEC_INDEX, BUSY and DONE. Internal pointer and counter clear to 0.
- A reset mid-run abandons the run. No DONE is issued.
- States: IDLE, RD_LO, RD_HI, CAP, PRESENT, FINISH.
- IDLE:
  - On START, latch ptr = {BASE_ADDR[RAM_ADDR_BITS-1:2], 2'b00} and remaining = NUM_VEC.
  - If NUM_VEC == 0, go to FINISH; otherwise go to RD_LO.
  - BUSY rises the cycle after START.
- RD_LO: EN_A=EN_B=1, ADDR_A=ptr, ADDR_B=ptr+1, then go to RD_HI.
- RD_HI:
  - EN_A=EN_B=1, ADDR_A=ptr+2, ADDR_B=ptr+3.
  - Capture DOUT_A into VEC_OUT[31:0] and DOUT_B into VEC_OUT[63:32].
  - Go to CAP.
- CAP:
  - EN_A=EN_B=0.
  - Capture DOUT_A into [95:64] and DOUT_B into [127:96].
  - VEC_VALID is set registered, so it is high on entry to PRESENT.
- PRESENT:
  - Hold VEC_OUT, VEC_INDEX and VEC_VALID stable until VEC_READY.
  - On handshake: clear VEC_VALID, ptr += 4, VEC_INDEX += 1, remaining -= 1.
  - If remaining was 1, go to FINISH; otherwise go to RD_LO.
- FINISH: DONE=1 for exactly one cycle, BUSY cleared, return to IDLE. VEC_INDEX is reset to 0 on the next START.
- Latency: START to first VEC_VALID is 4 cycles. Steady state with VEC_READY held high is 4 cycles per vector.
- Address arithmetic is modulo 2^RAM_ADDR_BITS. A run crossing the top of memory wraps to address 0 without error.
- START while BUSY is ignored, with no effect on the run.
- VEC_READY asserted while VEC_VALID=0 is ignored.
- EN_* is low in all states except RD_LO and RD_HI. WE_* is never asserted.

Optional Feature:
- Macro: BRAM_VECTOR_FETCH_CHECKSUM_EN.
- With the macro defined:
  - Extra output CHECKSUM [4*RAM_WIDTH-1:0], the running XOR of every vector accepted by handshake.
  - CHECKSUM clears on accepted START and on RST, and holds after DONE.
  - Used by the host to verify the BRAM contents.
- Without the macro: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..FINISH);
  - VEC_WORDS=4;
  - default RAM_WIDTH and RAM_ADDR_BITS, shared with the BRAM instance.
- One natural sub-module: bram_vector_assemble. It holds the 128-bit capture register with per-lane load enables (lo/hi) and the optional checksum XOR.
- The FSM, pointer and counters stay in the top module.

Test Plan:
- Preload words 0x100..0x107 = 0x0..0x7. START, BASE_ADDR=0x100, NUM_VEC=2, VEC_READY=1:
  - VEC_OUT = 0x00000003_00000002_00000001_00000000 (index 0), then 0x7_6_5_4 (index 1);
  - VEC_VALID first rises 4 cycles after START;
  - DONE pulses once.
- Same run with VEC_READY low for 10 cycles on vector 0: VEC_OUT, VEC_VALID and VEC_INDEX remain stable. No BRAM enables are asserted during the stall.
- BASE_ADDR=0x1FFC, NUM_VEC=2: second vector is read from addresses 0x0000..0x0003 (wrap).
- NUM_VEC=0: DONE pulses 2 cycles after START. VEC_VALID never rises and EN_A/EN_B stay 0.
- START re-pulsed mid-run: run unaffected. Then assert RST during PRESENT of vector 1 of 3: all outputs go to 0 immediately and there is no DONE. A fresh START then works normally.
- With BRAM_VECTOR_FETCH_CHECKSUM_EN defined, fetch the two vectors of scenario 1: CHECKSUM = 0x00000004_00000004_00000004_00000004.

Source files
------------

// File: rtl/bram_vector_fetch_pkg.sv
// bram_vector_fetch_pkg
//   Shared definitions for the vector BRAM fetch sequencer: sequencer state
//   type, words per vector and the default BRAM geometry. The geometry
//   defaults are also meant for the BRAM instance.
//   Optional feature macro used by the importing files:
//   BRAM_VECTOR_FETCH_CHECKSUM_EN.
package bram_vector_fetch_pkg;

  localparam int unsigned VEC_WORDS         = 4;
  localparam int unsigned DEF_RAM_WIDTH     = 32;
  localparam int unsigned DEF_RAM_ADDR_BITS = 13;
  localparam int unsigned DEF_CNT_BITS      = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_CAP,
    S_PRESENT,
    S_FINISH
  } state_e;

endpackage

// File: rtl/bram_vector_assemble.sv
// bram_vector_assemble
//   128-bit vector capture register. It has two lane loads:
//   - load_lo writes {dout_b, dout_a} into the low half;
//   - load_hi writes {dout_b, dout_a} into the high half.
//   Ports:
//   - clk, rst   : clock and asynchronous active-high reset.
//   - load_lo    : lane load enable for the low half.
//   - load_hi    : lane load enable for the high half.
//   - dout_a/b   : BRAM read data.
//   - vec        : assembled vector.
//   With BRAM_VECTOR_FETCH_CHECKSUM_EN defined there are extra ports:
//   - clr        : clears the checksum when a run is accepted.
//   - accept     : handshake strobe.
//   - checksum   : running XOR of every accepted vector.
module bram_vector_assemble
  import bram_vector_fetch_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = DEF_RAM_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_lo,
  input  logic                           load_hi,
  input  logic [RAM_WIDTH-1:0]           dout_a,
  input  logic [RAM_WIDTH-1:0]           dout_b,
`ifdef BRAM_VECTOR_FETCH_CHECKSUM_EN
  input  logic                           clr,
  input  logic                           accept,
  output logic [VEC_WORDS*RAM_WIDTH-1:0] checksum,
`endif
  output logic [VEC_WORDS*RAM_WIDTH-1:0] vec
);

  localparam int unsigned HALF = 2 * RAM_WIDTH;

  logic [VEC_WORDS*RAM_WIDTH-1:0] vec_q, vec_d;

  always_comb begin
    vec_d = vec_q;
    if (load_lo) vec_d[HALF-1:0]              = {dout_b, dout_a};
    if (load_hi) vec_d[2*HALF-1:HALF]         = {dout_b, dout_a};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vec_q <= '0;
    else     vec_q <= vec_d;
  end

  assign vec = vec_q;

`ifdef BRAM_VECTOR_FETCH_CHECKSUM_EN
  logic [VEC_WORDS*RAM_WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (clr)         checksum_d = '0;
    else if (accept) checksum_d = checksum_q ^ vec_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: rtl/bram_vector_fetch.sv
// bram_vector_fetch
//   Sequencer that fetches 128-bit vectors from a 32-bit dual-port BRAM.
//   Each vector is four adjacent words. It is read in two cycles using both
//   ports, then presented downstream on a valid/ready handshake.
//   Ports:
//   - CLK, RST              : clock and asynchronous active-high reset.
//   - START                 : start pulse, sampled only when idle.
//   - BASE_ADDR             : word address of vector 0; bits [1:0] ignored.
//   - NUM_VEC               : number of vectors to fetch.
//   - BUSY, DONE            : run in progress; one-cycle completion pulse.
//   - EN_*, WE_*, ADDR_*,
//     DIN_*, DOUT_*         : BRAM port A/B interface. The BRAM is read only.
//   - VEC_OUT, VEC_VALID,
//     VEC_READY, VEC_INDEX  : downstream vector handshake and vector index.
//   Optional macro BRAM_VECTOR_FETCH_CHECKSUM_EN adds the CHECKSUM output.
module bram_vector_fetch
  import bram_vector_fetch_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int unsigned RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
  parameter int unsigned CNT_BITS      = DEF_CNT_BITS
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           START,
  input  logic [RAM_ADDR_BITS-1:0]       BASE_ADDR,
  input  logic [CNT_BITS-1:0]            NUM_VEC,
  output logic                           BUSY,
  output logic                           DONE,
  output logic                           EN_A,
  output logic                           EN_B,
  output logic                           WE_A,
  output logic                           WE_B,
  output logic [RAM_ADDR_BITS-1:0]       ADDR_A,
  output logic [RAM_ADDR_BITS-1:0]       ADDR_B,
  output logic [RAM_WIDTH-1:0]           DIN_A,
  output logic [RAM_WIDTH-1:0]           DIN_B,
  input  logic [RAM_WIDTH-1:0]           DOUT_A,
  input  logic [RAM_WIDTH-1:0]           DOUT_B,
  output logic [VEC_WORDS*RAM_WIDTH-1:0] VEC_OUT,
  output logic                           VEC_VALID,
  input  logic                           VEC_READY,
`ifdef BRAM_VECTOR_FETCH_CHECKSUM_EN
  output logic [VEC_WORDS*RAM_WIDTH-1:0] CHECKSUM,
`endif
  output logic [CNT_BITS-1:0]            VEC_INDEX
);

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [CNT_BITS-1:0]      remaining_q, remaining_d;
  logic [CNT_BITS-1:0]      index_q, index_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     en_q, en_d;
  logic [RAM_ADDR_BITS-1:0] addr_a_q, addr_a_d;
  logic [RAM_ADDR_BITS-1:0] addr_b_q, addr_b_d;
  logic                     valid_q, valid_d;

  logic [RAM_ADDR_BITS-1:0] base_aligned;
  logic [RAM_ADDR_BITS-1:0] next_ptr;
  logic                     handshake;

  assign handshake = (state_q == S_PRESENT) && valid_q && VEC_READY;

  // Port enables and addresses are registered. The values for the next
  // state are loaded on the transition into it, so they line up with
  // RD_LO/RD_HI without any combinational path to the BRAM pins.
  always_comb begin
    base_aligned = BASE_ADDR & ~RAM_ADDR_BITS'(3);
    next_ptr     = ptr_q + RAM_ADDR_BITS'(VEC_WORDS);

    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    en_d        = 1'b0;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    valid_d     = valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          ptr_d       = base_aligned;
          remaining_d = NUM_VEC;
          index_d     = '0;
          busy_d      = 1'b1;
          if (NUM_VEC == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d  = S_RD_LO;
            en_d     = 1'b1;
            addr_a_d = base_aligned;
            addr_b_d = base_aligned + RAM_ADDR_BITS'(1);
          end
        end
      end
      S_RD_LO: begin
        state_d  = S_RD_HI;
        en_d     = 1'b1;
        addr_a_d = ptr_q + RAM_ADDR_BITS'(2);
        addr_b_d = ptr_q + RAM_ADDR_BITS'(3);
      end
      S_RD_HI: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        state_d = S_PRESENT;
        valid_d = 1'b1;
      end
      S_PRESENT: begin
        if (handshake) begin
          valid_d     = 1'b0;
          ptr_d       = next_ptr;
          index_d     = index_q + CNT_BITS'(1);
          remaining_d = remaining_q - CNT_BITS'(1);
          if (remaining_q == CNT_BITS'(1)) begin
            state_d = S_FINISH;
          end else begin
            state_d  = S_RD_LO;
            en_d     = 1'b1;
            addr_a_d = next_ptr;
            addr_b_d = next_ptr + RAM_ADDR_BITS'(1);
          end
        end
      end
      S_FINISH: begin
        // DONE and the BUSY drop are registered on leaving FINISH.
        // They are therefore seen in the first IDLE cycle.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      index_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      en_q        <= en_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      valid_q     <= valid_d;
    end
  end

  // Read data registered by the BRAM during RD_LO arrives in RD_HI.
  // Read data registered during RD_HI arrives in CAP.
  bram_vector_assemble #(
    .RAM_WIDTH (RAM_WIDTH)
  ) u_assemble (
    .clk      (CLK),
    .rst      (RST),
    .load_lo  (state_q == S_RD_HI),
    .load_hi  (state_q == S_CAP),
    .dout_a   (DOUT_A),
    .dout_b   (DOUT_B),
`ifdef BRAM_VECTOR_FETCH_CHECKSUM_EN
    .clr      ((state_q == S_IDLE) && START),
    .accept   (handshake),
    .checksum (CHECKSUM),
`endif
    .vec      (VEC_OUT)
  );

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign EN_A      = en_q;
  assign EN_B      = en_q;
  assign WE_A      = 1'b0;
  assign WE_B      = 1'b0;
  assign ADDR_A    = addr_a_q;
  assign ADDR_B    = addr_b_q;
  assign DIN_A     = '0;
  assign DIN_B     = '0;
  assign VEC_VALID = valid_q;
  assign VEC_INDEX = index_q;

endmodule
